// File: rtl/powlib_sdownsizer.sv
// Width down-converter: takes one R*W-bit word per valid/ready handshake and emits it
// as R beats of W bits, flagging the final beat. A new word can load on the last-beat handshake.
module powlib_sdownsizer #(
  parameter int W    = 16,
  parameter int R    = 4,
  parameter int EMSB = 0,
  parameter int EDBG = 0,
  parameter     ID   = "SDOWN",
  localparam int WCNT = (R > 1) ? $clog2(R) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R*W-1:0]    wrdata,
  input  logic              wrvld,
  output logic              wrrdy,
  output logic [W-1:0]      rddata,
  output logic              rdvld,
  input  logic              rdrdy,
  output logic              rdlast,
  output logic [0:0]        dbg_state,
  output logic [WCNT-1:0]   dbg_cnt
);

  localparam logic [0:0]      IDLE = 1'b0;
  localparam logic [0:0]      SEND = 1'b1;
  localparam logic [WCNT-1:0] LAST = WCNT'(R - 1);

  if (R < 1 || W < 1 || EDBG < 0 || EDBG > 1) begin : g_param_err
    $fatal(1, "%s: illegal parameters (R and W must be >= 1, EDBG 0 or 1)", ID);
  end

  logic [0:0]            state_q, state_d;
  logic [WCNT-1:0]       cnt_q, cnt_d;
  logic [R-1:0][W-1:0]   hold_q, hold_d;
  logic [WCNT-1:0]       beat_idx;
  logic                  busy, wrinc, rdinc;

  assign busy   = (state_q == SEND);
  assign rdvld  = busy;
  assign rdlast = busy && (cnt_q == LAST);
  assign wrrdy  = !busy || (rdrdy && rdlast);
  assign wrinc  = wrvld && wrrdy;
  assign rdinc  = rdvld && rdrdy;

  // cnt_q is the transmit order; EMSB only changes which slice of the word that maps to.
  assign beat_idx = (EMSB != 0) ? (LAST - cnt_q) : cnt_q;
  assign rddata   = hold_q[beat_idx];

  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (wrinc) begin
          hold_d  = wrdata;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (rdinc) begin
          if (cnt_q != LAST) begin
            cnt_d = cnt_q + WCNT'(1);
          end else begin
            cnt_d = '0;
            if (wrinc) begin
              hold_d = wrdata;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_powlib_sdownsizer.sv
// Bench for powlib_sdownsizer: four instances (R=4 LSB-first, R=4 MSB-first, R=3, R=1),
// exercised one at a time against a beat-queue reference model.
module tb_powlib_sdownsizer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][31:0] wd;
  logic [3:0]       wv, wr, rv, rr, rl, st;
  logic [3:0][7:0]  rd;
  logic [1:0]       cnt_lsb, cnt_msb, cnt_r3;
  logic [0:0]       cnt_r1;

  int rpar [4] = '{4, 4, 3, 1};
  int emsb [4] = '{0, 1, 0, 0};

  powlib_sdownsizer #(.W(8), .R(4), .EMSB(0)) u_lsb (
    .clk(clk), .rst(rst), .wrdata(wd[0]), .wrvld(wv[0]), .wrrdy(wr[0]),
    .rddata(rd[0]), .rdvld(rv[0]), .rdrdy(rr[0]), .rdlast(rl[0]),
    .dbg_state(st[0:0]), .dbg_cnt(cnt_lsb));
  powlib_sdownsizer #(.W(8), .R(4), .EMSB(1)) u_msb (
    .clk(clk), .rst(rst), .wrdata(wd[1]), .wrvld(wv[1]), .wrrdy(wr[1]),
    .rddata(rd[1]), .rdvld(rv[1]), .rdrdy(rr[1]), .rdlast(rl[1]),
    .dbg_state(st[1:1]), .dbg_cnt(cnt_msb));
  powlib_sdownsizer #(.W(8), .R(3), .EMSB(0)) u_r3 (
    .clk(clk), .rst(rst), .wrdata(wd[2][23:0]), .wrvld(wv[2]), .wrrdy(wr[2]),
    .rddata(rd[2]), .rdvld(rv[2]), .rdrdy(rr[2]), .rdlast(rl[2]),
    .dbg_state(st[2:2]), .dbg_cnt(cnt_r3));
  powlib_sdownsizer #(.W(8), .R(1), .EMSB(0)) u_r1 (
    .clk(clk), .rst(rst), .wrdata(wd[3][7:0]), .wrvld(wv[3]), .wrrdy(wr[3]),
    .rddata(rd[3]), .rdvld(rv[3]), .rdrdy(rr[3]), .rdlast(rl[3]),
    .dbg_state(st[3:3]), .dbg_cnt(cnt_r1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int cnt_of(input int k);
    case (k)
      0: return int'(cnt_lsb);
      1: return int'(cnt_msb);
      2: return int'(cnt_r3);
      default: return int'(cnt_r1);
    endcase
  endfunction

  // Reference model: each beat pending on the active instance, {last, data}, in output order.
  logic [8:0]  exp_q[$];
  logic [31:0] src_q[$];
  int act    = 0;
  bit mon_en = 1'b0;

  // Handshakes seen here complete on the following rising edge; inputs change only after rising edges.
  always @(negedge clk) begin
    int k, r, sh;
    logic [31:0] w;
    if (rst && mon_en) begin
      k = act;
      r = rpar[k];
      check("rdvld", rv[k], exp_q.size() != 0);
      check("state", st[k], exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        check("rddata", rd[k], exp_q[0][7:0]);
        check("rdlast", rl[k], exp_q[0][8]);
      end
      check("wrrdy", wr[k], (exp_q.size() == 0) || (exp_q.size() == 1 && rr[k]));
      check("cnt_range", cnt_of(k) <= r - 1, 1);
      if (rv[k] && rr[k] && exp_q.size() != 0) void'(exp_q.pop_front());
      if (wv[k] && wr[k]) begin
        w = wd[k];
        for (int i = 0; i < r; i++) begin
          sh = (emsb[k] != 0) ? (r - 1 - i) : i;
          exp_q.push_back({(i == r - 1), 8'(w >> (8 * sh))});
        end
      end
    end
  end

  task automatic idle_all();
    wv = '0;
    rr = '0;
    for (int k = 0; k < 4; k++) wd[k] = $urandom;
  endtask

  // Drives src_q into instance k; pv/pr are percent chances of wrvld/rdrdy each cycle.
  task automatic run_stream(input int k, input int pv, input int pr, output int cyc);
    cyc = 0;
    act = k;
    mon_en = 1'b1;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < 4000) begin
      @(posedge clk); #1;
      if (src_q.size() != 0 && $urandom_range(99) < pv) begin
        wv[k] = 1'b1;
        wd[k] = src_q[0];
      end else begin
        wv[k] = 1'b0;
        wd[k] = $urandom;
      end
      rr[k] = ($urandom_range(99) < pr);
      @(negedge clk); #1;
      if (wv[k] && wr[k]) void'(src_q.pop_front());
      cyc++;
    end
    check("stream_done", (src_q.size() == 0) && (exp_q.size() == 0), 1);
    @(posedge clk); #1;
    idle_all();
  endtask

  initial begin
    int cyc;
    idle_all();

    // Reset held with wrvld asserted on every instance.
    rst = 1'b0;
    wv = '1;
    rr = '1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("rst_rdvld", rv[k], 0);
      check("rst_rdlast", rl[k], 0);
      check("rst_rddata", rd[k], 0);
      check("rst_wrrdy", wr[k], 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_rdvld", rv, 4'b0000);
    idle_all();
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    act = 0;
    repeat (4) @(posedge clk);

    // Single word, LSB first: accept cycle plus four beats.
    src_q = '{32'hDDCCBBAA};
    run_stream(0, 100, 100, cyc);
    check("lsb_cycles", cyc, 5);

    src_q = '{32'hDDCCBBAA};
    run_stream(1, 100, 100, cyc);
    check("msb_cycles", cyc, 5);

    // Back-to-back words with no bubble.
    src_q = '{32'h03020100, 32'h07060504};
    run_stream(0, 100, 100, cyc);
    check("b2b_cycles", cyc, 9);

    // Random words with random backpressure.
    for (int i = 0; i < 100; i++) src_q.push_back($urandom);
    run_stream(0, 70, 50, cyc);
    for (int i = 0; i < 30; i++) src_q.push_back($urandom);
    run_stream(1, 70, 50, cyc);
    for (int i = 0; i < 40; i++) src_q.push_back($urandom);
    run_stream(2, 80, 60, cyc);
    for (int i = 0; i < 30; i++) src_q.push_back($urandom);
    run_stream(3, 70, 50, cyc);

    // R=1 sustains one word per clock.
    for (int i = 0; i < 50; i++) src_q.push_back($urandom);
    run_stream(3, 100, 100, cyc);
    check("r1_tput", cyc, 51);

    // Reset mid-word after beat 1 has left.
    act = 0;
    @(posedge clk); #1;
    wv[0] = 1'b1;
    wd[0] = 32'h44332211;
    rr[0] = 1'b1;
    @(posedge clk); #1;
    wv[0] = 1'b0;
    wd[0] = $urandom;
    cyc = 0;
    while (exp_q.size() != 2 && cyc < 20) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("midrst_reach", exp_q.size(), 2);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_rdvld", rv[0], 0);
    check("midrst_rdlast", rl[0], 0);
    check("midrst_rddata", rd[0], 0);
    check("midrst_wrrdy", wr[0], 1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    src_q = '{32'h88776655};
    run_stream(0, 100, 100, cyc);
    check("midrst_restart", cyc, 5);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
